mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have parameter MUL_LAT, default 5, the multiply result latency in cycles, legal range 1..15.
REQ-002 The module SHALL have parameter DIV_LAT, default 10, the divide result latency in cycles, legal range 1..15.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block SHALL reset immediately while reset==0.
REQ-005 start  input  1  EX-stage request; the op and the operands are valid in the same cycle.
REQ-006 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a  input  32  forwarded rs value.
REQ-008 b  input  32  forwarded rt value.
REQ-009 busy  output  1  registered flag; high while a MULT/DIV computation is in flight.
REQ-010 stall_req  output  1  combinational request to the hazard unit to stall ID for MFHI/MFLO/MD-class instructions.
REQ-011 hi  output  32  architectural HI register.
REQ-012 lo  output  32  architectural LO register.

Function
REQ-013 The module SHALL use two states: IDLE and RUN.
REQ-014 In IDLE, start with op in {MULT, MULTU, DIV, DIVU} SHALL latch the result into internal pending registers, load the counter with the latency, and move to RUN.
  - Multiply latency is MUL_LAT; divide latency is DIV_LAT.
  - busy SHALL go to 1 at the same edge.
REQ-015 In RUN, the counter SHALL decrement once per cycle.
  - In the cycle the counter reaches 1, the next edge SHALL write the pending values into HI and LO, clear busy, and return to IDLE.
  - busy is therefore high for exactly LAT cycles after the start edge.
REQ-016 HI and LO SHALL keep their old values throughout RUN.
  - They change only on the completion edge, or on an MTHI/MTLO edge.
REQ-017 MULT SHALL form the signed 64-bit product a*b: {HI, LO} = product.
REQ-018 MULTU SHALL form the same as MULT with both operands treated as unsigned.
REQ-019 DIV SHALL compute the signed quotient and remainder.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of a.
  - 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.
REQ-020 DIVU SHALL compute the unsigned quotient and remainder: LO = quotient, HI = remainder.
REQ-021 When b==0 for DIV or DIVU, the module SHALL still enter RUN for DIV_LAT cycles, but HI and LO SHALL stay unchanged at completion.
REQ-022 In IDLE, start with op MTHI SHALL write a into HI at the next edge; start with op MTLO SHALL write a into LO at the next edge.
  - busy SHALL stay 0 for both.
REQ-023 Any start in RUN SHALL be ignored, with no state change.
  - The hazard unit guarantees this does not happen because of stall_req; the bench SHALL still check that it is ignored.
REQ-024 stall_req SHALL be busy | (start & op in {MULT, MULTU, DIV, DIVU}).
REQ-025 An undefined op with start=1 SHALL be a no-op.
REQ-026 The counter SHALL be 4 bits wide and SHALL never wrap.
  - It holds at 0 in IDLE.

Reset
REQ-027 While reset==0, the module SHALL be forced to:
  - hi=0, lo=0, busy=0;
  - counter=0, state=IDLE;
  - pending registers=0.
REQ-028 A reset asserted mid-RUN SHALL abandon the operation with no write to HI/LO.
  - After release, the first start SHALL be accepted normally.

Structure
REQ-029 The op encodings SHALL be defined as `defines in macro.v, shared with the decoder and the Hazard_Unit.
  - The codes are MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
REQ-030 The module SHALL be a single module with no sub-module.
  - Products and quotients come from behavioural *, / and %; the latency is modelled by the counter, not by an iterative datapath.
REQ-031 The module SHALL be instantiated in the EX stage, fed by the forwarded ALU operands.
  - stall_req SHALL be ORed into the Hazard_Unit stall.

Verification
REQ-032 Signed multiply: start, MULT, a=0xFFFFFFFE (-2), b=3.
  - Expect busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
  - HI/LO stay unchanged before completion.
REQ-033 Unsigned multiply: MULTU, a=b=0xFFFFFFFF.
  - After 5 cycles, expect HI=0xFFFFFFFE and LO=0x00000001.
REQ-034 Signed divide: DIV, a=-7, b=2.
  - busy is high for 10 cycles.
  - Then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - Also run DIV a=0x80000000, b=-1: expect LO=0x80000000, HI=0.
REQ-035 Divide by zero: preload with MTHI 0x11 and MTLO 0x22, then DIVU with b=0.
  - busy is high for 10 cycles.
  - Expect HI=0x11 and LO=0x22 unchanged.
REQ-036 Start during RUN: issue MULT 3*4; 2 cycles later issue MTLO 0x55 and DIV 9/3.
  - Expect both to be ignored.
  - Expect final LO=12 and HI=0.
  - Expect stall_req=1 throughout busy.
REQ-037 Reset mid-operation: pull reset low 3 cycles into DIVU 100/7.
  - Expect HI=LO=0 and busy=0 immediately, asynchronously.
  - After release, MULT 2*2 SHALL give LO=4 after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU op-code macros (used by the decoder and hazard unit too) and
// the package carrying the MDU state type and matching op-code constants.
`ifndef MDU_MACROS_SVH
`define MDU_MACROS_SVH
`define MD_MULT  3'd0
`define MD_MULTU 3'd1
`define MD_DIV   3'd2
`define MD_DIVU  3'd3
`define MD_MTHI  3'd4
`define MD_MTLO  3'd5
`endif

package mdu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam logic [2:0] OP_MULT  = `MD_MULT;
  localparam logic [2:0] OP_MULTU = `MD_MULTU;
  localparam logic [2:0] OP_DIV   = `MD_DIV;
  localparam logic [2:0] OP_DIVU  = `MD_DIVU;
  localparam logic [2:0] OP_MTHI  = `MD_MTHI;
  localparam logic [2:0] OP_MTLO  = `MD_MTLO;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: behavioural result computed at start, held in
// pending registers and committed to HI/LO after a fixed counter-modelled latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] hi_pend;
  logic [31:0] lo_pend;

  function automatic logic [63:0] mul_res(input logic [2:0] mop, input logic [31:0] x,
                                          input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    up = {32'd0, x} * {32'd0, y};
    return (mop == OP_MULT) ? sp : up;
  endfunction

  // Returns {hi, lo}; a zero divisor reproduces the current HI/LO so the
  // completion write leaves them unchanged.
  function automatic logic [63:0] div_res(input logic [2:0] mop, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] cur_hi,
                                          input logic [31:0] cur_lo);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sx = x;
    sy = y;
    if (y == 32'd0) return {cur_hi, cur_lo};
    if (mop == OP_DIVU) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
    sq = sx / sy;
    sr = sx % sy;
    return {sr, sq};
  endfunction

  assign stall_req = busy | (start & is_md_op(op));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {hi_pend, lo_pend} <= mul_res(op, a, b);
                cnt   <= MUL_CNT;
                busy  <= 1'b1;
                state <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                {hi_pend, lo_pend} <= div_res(op, a, b, hi, lo);
                cnt   <= DIV_CNT;
                busy  <= 1'b1;
                state <= ST_RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Any start arriving here is deliberately ignored.
          if (cnt == 4'd1) begin
            hi    <= hi_pend;
            lo    <= lo_pend;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO/latency queued at issue, checked at completion.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mdu #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] mop, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] oh,
                                 input logic [31:0] ol);
    exp_t        e;
    longint      sx, sy, p, q, r;
    logic [63:0] ux, uy, up;
    e.hi = oh; e.lo = ol; e.lat = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (mop)
      OP_MULT:  begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT; end
      OP_MULTU: begin up = ux * uy; e.hi = up[63:32]; e.lo = up[31:0]; e.lat = MUL_LAT; end
      OP_DIV: begin
        e.lat = DIV_LAT;
        if (y != 0) begin q = sx / sy; r = sx % sy; e.hi = r[31:0]; e.lo = q[31:0]; end
      end
      OP_DIVU: begin
        e.lat = DIV_LAT;
        if (y != 0) begin up = ux / uy; e.lo = up[31:0]; up = ux % uy; e.hi = up[31:0]; end
      end
      OP_MTHI: e.hi = x;
      OP_MTLO: e.lo = x;
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op, watch the busy window, then pop and compare the scoreboard.
  task automatic do_op(input string name, input logic [2:0] mop, input logic [31:0] x,
                       input logic [31:0] y);
    exp_t        e;
    logic [31:0] oh, ol;
    int          cyc;
    bit          hold_ok, stall_ok;
    oh = hi; ol = lo;
    sb.push_back(model(mop, x, y, oh, ol));
    @(negedge clk);
    start = 1'b1; op = mop; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hold_ok = 1; stall_ok = 1;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== oh || lo !== ol) hold_ok = 0;
      if (stall_req !== 1'b1) stall_ok = 0;
      @(negedge clk);
    end
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL %s busy_cycles got %0d want %0d", name, cyc, e.lat); end
    n_cmp++;
    if (!hold_ok) begin n_err++; $display("FAIL %s hilo_hold changed during busy, want %h/%h", name, oh, ol); end
    n_cmp++;
    if (!stall_ok) begin n_err++; $display("FAIL %s stall_during_busy got 0 want 1", name); end
    n_cmp++;
    if (hi !== e.hi) begin n_err++; $display("FAIL %s hi got %h want %h", name, hi, e.hi); end
    n_cmp++;
    if (lo !== e.lo) begin n_err++; $display("FAIL %s lo got %h want %h", name, lo, e.lo); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hi !== 32'd0)   begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0)   begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_req); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall_comb();
    start = 1'b1; op = OP_DIV; a = 32'd1; b = 32'd1;
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL stall_comb_md got %b want 1", stall_req); end
    op = OP_MTHI;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL stall_comb_mthi got %b want 0", stall_req); end
    start = 1'b0;
  endtask

  task automatic test_mult();
    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++; $display("FAIL mult_neg_const got %h_%h want ffffffff_fffffffa", hi, lo);
    end
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_err++; $display("FAIL multu_max_const got %h_%h want fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL div_neg_const got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      n_err++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_divzero();
    do_op("mthi", OP_MTHI, 32'h11, 32'd0);
    do_op("mtlo", OP_MTLO, 32'h22, 32'd0);
    do_op("divu_zero", OP_DIVU, 32'd1234, 32'd0);
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_err++; $display("FAIL divu_zero_const got %h_%h want 00000011_00000022", hi, lo);
    end
    do_op("div_zero", OP_DIV, 32'hFFFF_0000, 32'd0);
  endtask

  task automatic test_undef_op();
    do_op("undef6", 3'd6, 32'hDEAD_BEEF, 32'd5);
    do_op("undef7", 3'd7, 32'hCAFE_F00D, 32'd9);
  endtask

  task automatic test_start_in_run();
    int  cyc;
    bit  stall_ok, hold_ok;
    logic [31:0] oh, ol;
    oh = hi; ol = lo;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    cyc = 0; stall_ok = 1; hold_ok = 1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (stall_req !== 1'b1) stall_ok = 0;
      if (hi !== oh || lo !== ol) hold_ok = 0;
      start = (k == 2) || (k == 3);
      op = (k == 2) ? OP_MTLO : OP_DIV;
      a  = (k == 2) ? 32'h55 : 32'd9;
      b  = 32'd3;
    end
    start = 1'b0;
    n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL run_ign_cycles got %0d want %0d", cyc, MUL_LAT); end
    n_cmp++; if (!stall_ok) begin n_err++; $display("FAIL run_ign_stall got 0 want 1"); end
    n_cmp++; if (!hold_ok) begin n_err++; $display("FAIL run_ign_hold changed want %h/%h", oh, ol); end
    n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL run_ign_lo got %h want 0000000c", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL run_ign_hi got %h want 0", hi); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_ign_relaunch busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op("mult_after_rst", OP_MULT, 32'd2, 32'd2);
    n_cmp++; if (lo !== 32'd4) begin n_err++; $display("FAIL mult_after_rst_const got %h want 4", lo); end
  endtask

  task automatic test_random();
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      if (rb == 0) rb = 32'd1;
      do_op("rand", rop, ra, rb);
    end
  endtask

  initial begin
    test_reset();
    test_stall_comb();
    test_mult();
    test_div();
    test_divzero();
    test_undef_op();
    test_start_in_run();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
